// File: rtl/alarm_annunciator.sv
// alarm_annunciator
// Consumer end of the emergency alarm line. Turns a level alarm request into
// a beeping square-wave buzzer drive with an on/off cadence, a matching LED
// blink, and a user silence function that re-arms after a fixed time.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   alarm_req    level alarm request from the emergency controller
//   btn_silence  debounced silence button; only its rising edge acts
//   buzzer_pwm   tone drive to the buzzer (registered)
//   led_blink    alert LED drive (registered)
//   silenced     high while the alarm is silenced (registered)
//   state        FSM state: 0 IDLE, 1 SOUND_ON, 2 SOUND_OFF, 3 SILENCED
//
// Build option:
//   ANNUNC_ESCALATE_EN  when defined, after four completed off phases the
//                       tone stays on continuously until the request drops
//                       or the user silences the alarm.

module alarm_annunciator #(
  parameter int TONE_HALF_CYC = 12500,
  parameter int ON_CYC        = 25000000,
  parameter int OFF_CYC       = 25000000,
  parameter int SILENCE_CYC   = 1500000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       alarm_req,
  input  logic       btn_silence,
  output logic       buzzer_pwm,
  output logic       led_blink,
  output logic       silenced,
  output logic [1:0] state
);

  localparam int TW  = $clog2(TONE_HALF_CYC + 1);
  localparam int ONW = $clog2(ON_CYC + 1);
  localparam int OFW = $clog2(OFF_CYC + 1);
  localparam int SLW = $clog2(SILENCE_CYC + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SOUND_ON  = 2'd1,
    SOUND_OFF = 2'd2,
    SILENCED  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    tone_q, tone_d;
  logic [ONW-1:0]   on_q, on_d;
  logic [OFW-1:0]   off_q, off_d;
  logic [SLW-1:0]   sil_q, sil_d;
  logic             btn_q;
  logic             buzzer_q, buzzer_d;
  logic             led_q, led_d;
  logic             silenced_q, silenced_d;

  logic             sil_edge;
  logic             entry;
  logic             tone_wrap;
  logic             on_done;
  logic             off_done;
  logic             sil_done;
  logic             escalated;

  assign sil_edge  = btn_silence & ~btn_q;
  assign tone_wrap = (tone_q == TW'(TONE_HALF_CYC - 1));
  assign on_done   = (on_q   == ONW'(ON_CYC - 1));
  assign off_done  = (off_q  == OFW'(OFF_CYC - 1));
  assign sil_done  = (sil_q  == SLW'(SILENCE_CYC - 1));

`ifdef ANNUNC_ESCALATE_EN
  // Counts off phases that ran to completion since the alarm last started
  // from IDLE or SILENCED; saturates at 4, which locks the tone on.
  logic [2:0] esc_q, esc_d;

  always_comb begin
    esc_d = esc_q;
    if (state_d == IDLE || state_d == SILENCED) begin
      esc_d = 3'd0;
    end else if (state_q == SOUND_OFF && state_d == SOUND_ON && esc_q != 3'd4) begin
      esc_d = esc_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      esc_q <= 3'd0;
    end else begin
      esc_q <= esc_d;
    end
  end

  assign escalated = (esc_q == 3'd4);
`else
  assign escalated = 1'b0;
`endif

  // Next-state decision. A dropped request beats a silence edge, which beats
  // phase expiry; silence edges do nothing outside the sounding states.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (alarm_req) state_d = SOUND_ON;
      end
      SOUND_ON: begin
        if (!alarm_req)                  state_d = IDLE;
        else if (sil_edge)               state_d = SILENCED;
        else if (on_done && !escalated)  state_d = SOUND_OFF;
      end
      SOUND_OFF: begin
        if (!alarm_req)    state_d = IDLE;
        else if (sil_edge) state_d = SILENCED;
        else if (off_done) state_d = SOUND_ON;
      end
      SILENCED: begin
        if (!alarm_req)    state_d = IDLE;
        else if (sil_done) state_d = SOUND_ON;
      end
      default: state_d = IDLE;
    endcase
  end

  assign entry = (state_d != state_q);

  // Counters and registered outputs. Every state change clears all counters;
  // otherwise only the counters belonging to the current state advance.
  // The tone restarts high on every entry to SOUND_ON.
  always_comb begin
    tone_d     = '0;
    on_d       = '0;
    off_d      = '0;
    sil_d      = '0;
    buzzer_d   = 1'b0;
    led_d      = 1'b0;
    silenced_d = 1'b0;
    if (!entry) begin
      case (state_q)
        SOUND_ON: begin
          tone_d = tone_wrap ? '0 : tone_q + TW'(1);
          on_d   = on_done ? on_q : on_q + ONW'(1);
        end
        SOUND_OFF: off_d = off_q + OFW'(1);
        SILENCED:  sil_d = sil_q + SLW'(1);
        default: ;
      endcase
    end
    case (state_d)
      SOUND_ON: begin
        led_d    = 1'b1;
        buzzer_d = entry ? 1'b1 : (tone_wrap ? ~buzzer_q : buzzer_q);
      end
      SILENCED: begin
        led_d      = 1'b1;
        silenced_d = 1'b1;
      end
      default: ;
    endcase
  end

  // State, counters, button delay flop and outputs all update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      tone_q     <= '0;
      on_q       <= '0;
      off_q      <= '0;
      sil_q      <= '0;
      btn_q      <= 1'b0;
      buzzer_q   <= 1'b0;
      led_q      <= 1'b0;
      silenced_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tone_q     <= tone_d;
      on_q       <= on_d;
      off_q      <= off_d;
      sil_q      <= sil_d;
      btn_q      <= btn_silence;
      buzzer_q   <= buzzer_d;
      led_q      <= led_d;
      silenced_q <= silenced_d;
    end
  end

  assign buzzer_pwm = buzzer_q;
  assign led_blink  = led_q;
  assign silenced   = silenced_q;
  assign state      = state_q;

endmodule

// File: tb/tb_alarm_annunciator.sv
// tb_alarm_annunciator
// Directed scenarios followed by a randomized run of alarm/button/reset
// activity. Every cycle the outputs are compared with a behavioural model
// that tracks the current mode and the time spent in it; the tone level is
// derived arithmetically from elapsed time in the sounding phase.

module tb_alarm_annunciator;

  localparam int TONE = 2;
  localparam int ONC  = 8;
  localparam int OFFC = 8;
  localparam int SILC = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       alarm_req;
  logic       btn_silence;
  logic       buzzer_pwm;
  logic       led_blink;
  logic       silenced;
  logic [1:0] state;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  // Model: mode 0 idle, 1 sounding, 2 pause, 3 silenced; mT cycles in mode.
  int mState = 0;
  int mT     = 0;
  int mEsc   = 0;
  bit mPrevBtn = 1'b0;

  alarm_annunciator #(
    .TONE_HALF_CYC(TONE),
    .ON_CYC(ONC),
    .OFF_CYC(OFFC),
    .SILENCE_CYC(SILC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .alarm_req(alarm_req),
    .btn_silence(btn_silence),
    .buzzer_pwm(buzzer_pwm),
    .led_blink(led_blink),
    .silenced(silenced),
    .state(state)
  );

  always #5 clk = ~clk;

  // Hard stop in case something goes badly wrong with time advancing.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic expectVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance the reference model by one clock edge using the sampled inputs.
  task automatic modelStep(input bit a, input bit b, input bit r);
    int  nxt;
    bit  edgeSeen;
    bit  locked;
    if (r) begin
      mState = 0; mT = 0; mEsc = 0; mPrevBtn = 1'b0;
      return;
    end
    edgeSeen = b && !mPrevBtn;
    mPrevBtn = b;
`ifdef ANNUNC_ESCALATE_EN
    locked = (mEsc >= 4);
`else
    locked = 1'b0;
`endif
    nxt = mState;
    case (mState)
      0: if (a) nxt = 1;
      1: begin
        if (!a) nxt = 0;
        else if (edgeSeen) nxt = 3;
        else if (mT + 1 >= ONC && !locked) nxt = 2;
      end
      2: begin
        if (!a) nxt = 0;
        else if (edgeSeen) nxt = 3;
        else if (mT + 1 >= OFFC) begin
          nxt = 1;
          mEsc++;
        end
      end
      default: begin
        if (!a) nxt = 0;
        else if (mT + 1 >= SILC) nxt = 1;
      end
    endcase
    if (nxt != mState) begin
      mT = 0;
      if (nxt == 0 || nxt == 3) mEsc = 0;
    end else begin
      mT++;
    end
    mState = nxt;
  endtask

  task automatic checkOutput();
    logic expBuz;
    expBuz = (mState == 1) && (((mT / TONE) % 2) == 0);
    expectVal("model_state", 32'(state), 32'(mState));
    expectVal("model_buzzer", 32'(buzzer_pwm), 32'(expBuz));
    expectVal("model_led", 32'(led_blink), 32'((mState == 1) || (mState == 3)));
    expectVal("model_silenced", 32'(silenced), 32'(mState == 3));
  endtask

  // Drive inputs just after an edge, let the next edge sample them, then
  // compare #1 later.
  task automatic applyStimulus(input logic a, input logic b, input logic r);
    alarm_req   = a;
    btn_silence = b;
    reset       = r;
    @(posedge clk);
    #1;
    modelStep(a, b, r);
    checkOutput();
  endtask

  initial begin
    int pat [8];
    pat = '{1, 1, 0, 0, 1, 1, 0, 0};
    alarm_req = 1'b0; btn_silence = 1'b0; reset = 1'b1;

    $display("[TB] scenario 1: reset, entry latency and cadence");
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    expectVal("reset_state", 32'(state), 32'd0);
    expectVal("reset_buzzer", 32'(buzzer_pwm), 32'd0);
    expectVal("reset_led", 32'(led_blink), 32'd0);
    expectVal("reset_silenced", 32'(silenced), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    expectVal("s1_entry_state", 32'(state), 32'd1);
    expectVal("s1_entry_buzzer", 32'(buzzer_pwm), 32'd1);
    expectVal("s1_entry_led", 32'(led_blink), 32'd1);
    for (int i = 1; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      expectVal("s1_cadence", 32'(buzzer_pwm), 32'(pat[i]));
    end
    applyStimulus(1'b1, 1'b0, 1'b0);
    expectVal("s1_off_state", 32'(state), 32'd2);
    expectVal("s1_off_buzzer", 32'(buzzer_pwm), 32'd0);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    expectVal("s1_off_hold", 32'(state), 32'd2);
    applyStimulus(1'b1, 1'b0, 1'b0);
    expectVal("s1_reon_state", 32'(state), 32'd1);
    expectVal("s1_reon_buzzer", 32'(buzzer_pwm), 32'd1);

    $display("[TB] scenario 2: request drop returns to idle");
    applyStimulus(1'b0, 1'b0, 1'b0);
    expectVal("s2_idle_state", 32'(state), 32'd0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    expectVal("s2_drop_state", 32'(state), 32'd0);
    expectVal("s2_drop_buzzer", 32'(buzzer_pwm), 32'd0);
    expectVal("s2_drop_led", 32'(led_blink), 32'd0);

    $display("[TB] scenario 3: silence and re-arm");
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    expectVal("s3_sil_state", 32'(state), 32'd3);
    expectVal("s3_sil_flag", 32'(silenced), 32'd1);
    expectVal("s3_sil_led", 32'(led_blink), 32'd1);
    expectVal("s3_sil_buzzer", 32'(buzzer_pwm), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 17; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    expectVal("s3_sil_last", 32'(state), 32'd3);
    applyStimulus(1'b1, 1'b0, 1'b0);
    expectVal("s3_rearm_state", 32'(state), 32'd1);
    expectVal("s3_rearm_buzzer", 32'(buzzer_pwm), 32'd1);

    $display("[TB] scenario 4: second edge ignored, drop while silenced");
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    expectVal("s4_sil_state", 32'(state), 32'd3);
    for (int k = 1; k < 20; k++) applyStimulus(1'b1, (k == 2), 1'b0);
    expectVal("s4_no_restart_hold", 32'(state), 32'd3);
    applyStimulus(1'b1, 1'b0, 1'b0);
    expectVal("s4_no_restart_rearm", 32'(state), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    expectVal("s4_drop_state", 32'(state), 32'd0);
    expectVal("s4_drop_silenced", 32'(silenced), 32'd0);

    $display("[TB] scenario 5: reset mid-tone");
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    expectVal("s5_reset_state", 32'(state), 32'd0);
    expectVal("s5_reset_buzzer", 32'(buzzer_pwm), 32'd0);
    expectVal("s5_reset_led", 32'(led_blink), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    expectVal("s5_after_reset_state", 32'(state), 32'd1);

`ifdef ANNUNC_ESCALATE_EN
    $display("[TB] scenario 6: escalation to continuous tone");
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 64; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 45; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      expectVal("s6_continuous", 32'(state), 32'd1);
    end
    applyStimulus(1'b1, 1'b1, 1'b0);
    expectVal("s6_silence", 32'(state), 32'd3);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    expectVal("s6_rearm", 32'(state), 32'd1);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    expectVal("s6_cadence_back", 32'(state), 32'd2);
`endif

    $display("[TB] randomized run");
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 15) != 0),
                    ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 149) == 0));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
